// File: rtl/npc_gen_pkg.sv
// Shared types for the next-PC generator: word type, forward class, FSM states.
package npc_gen_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    NO_FORWARD = 2'd0,
    PCW        = 2'd1,
    PCM        = 2'd2
  } forward_pc_type_t;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_PEND
  } npc_state_t;

  localparam word_t RESET_PC_DEFAULT = 32'hBFC00000;

endpackage

// File: rtl/npc_gen_redir_arb.sv
// Priority encoder over redirect sources: lowest set index wins, reports {hit, idx, pc, class}.
module npc_redir_arb
  import npc_gen_pkg::*;
#(
  parameter int unsigned NUM_REDIR    = 4,
  parameter int unsigned NUM_WB_REDIR = 2,
  localparam int unsigned IW          = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1
) (
  input  logic [NUM_REDIR-1:0]    i_valid,
  input  logic [NUM_REDIR*32-1:0] i_pc,
  output logic                    o_hit,
  output logic [IW-1:0]           o_idx,
  output word_t                   o_pc,
  output forward_pc_type_t        o_class
);

  always_comb begin
    o_hit   = 1'b0;
    o_idx   = '0;
    o_pc    = '0;
    o_class = NO_FORWARD;
    // Walk from the lowest priority upward so the lowest set index is written last.
    for (int unsigned k = NUM_REDIR; k > 0; k--) begin
      if (i_valid[k-1]) begin
        o_hit = 1'b1;
        o_idx = IW'(k - 1);
        o_pc  = i_pc[(k-1)*32 +: 32];
      end
    end
    if (o_hit) begin
      o_class = (32'(o_idx) < NUM_WB_REDIR) ? PCW : PCM;
    end
  end

endmodule

// File: rtl/npc_gen.sv
// Fetch PC owner: redirect/replay/predictor/sequential next-PC select with stalled-redirect buffering.
// Optional NPC_ALIGN_CHECK_EN adds fetch_adel, flagging a misaligned fetch_pc.
module npc_gen
  import npc_gen_pkg::*;
#(
  parameter int unsigned NUM_REDIR    = 4,
  parameter int unsigned NUM_WB_REDIR = 2,
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter word_t       RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_REDIR-1:0]    redir_valid,
  input  logic [NUM_REDIR*32-1:0] redir_pc,
  input  logic                    replay,
  input  logic                    pred_taken,
  input  logic [31:0]             pred_pc,
  output logic                    fetch_valid,
  output logic [31:0]             fetch_pc,
  input  logic                    fetch_ready,
  output logic                    fetch_kill,
  output forward_pc_type_t        forward_type
`ifdef NPC_ALIGN_CHECK_EN
  ,
  output logic                    fetch_adel
`endif
);

  localparam int unsigned IW   = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
  localparam word_t       STEP = 32'(4 * FETCH_WIDTH);

  npc_state_t       r_state, w_state_nxt;
  word_t            r_pc, w_pc_nxt;
  word_t            r_ppc, w_ppc_nxt;
  logic [IW-1:0]    r_pidx, w_pidx_nxt;
  forward_pc_type_t w_fwd, w_pcls;
  logic             w_kill;
  word_t            w_seq;

  logic                 w_a_hit, w_b_hit;
  logic [IW-1:0]        w_a_idx, w_b_idx;
  word_t                w_a_pc, w_b_pc;
  forward_pc_type_t     w_a_cls, w_b_cls;
  logic [NUM_REDIR-1:0] w_mask_valid;

  npc_redir_arb #(.NUM_REDIR(NUM_REDIR), .NUM_WB_REDIR(NUM_WB_REDIR)) u_arb_live (
    .i_valid (redir_valid),
    .i_pc    (redir_pc),
    .o_hit   (w_a_hit),
    .o_idx   (w_a_idx),
    .o_pc    (w_a_pc),
    .o_class (w_a_cls)
  );

  // Second arbiter sees only sources at or above the pending entry's priority.
  always_comb begin
    w_mask_valid = '0;
    for (int unsigned k = 0; k < NUM_REDIR; k++) begin
      w_mask_valid[k] = redir_valid[k] & (k <= 32'(r_pidx));
    end
  end

  npc_redir_arb #(.NUM_REDIR(NUM_REDIR), .NUM_WB_REDIR(NUM_WB_REDIR)) u_arb_pend (
    .i_valid (w_mask_valid),
    .i_pc    (redir_pc),
    .o_hit   (w_b_hit),
    .o_idx   (w_b_idx),
    .o_pc    (w_b_pc),
    .o_class (w_b_cls)
  );

  assign w_seq  = (r_pc & ~(STEP - 32'd1)) + STEP;
  assign w_pcls = (32'(r_pidx) < NUM_WB_REDIR) ? PCW : PCM;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ppc_nxt   = r_ppc;
    w_pidx_nxt  = r_pidx;
    w_fwd       = NO_FORWARD;
    w_kill      = 1'b0;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_a_hit) begin
          if (fetch_ready) begin
            w_pc_nxt = w_a_pc;
            w_fwd    = w_a_cls;
          end else begin
            w_pidx_nxt  = w_a_idx;
            w_ppc_nxt   = w_a_pc;
            w_state_nxt = S_PEND;
          end
        end else if (fetch_ready && !replay) begin
          w_pc_nxt = pred_taken ? pred_pc : w_seq;
        end
      end
      S_PEND: begin
        if (fetch_ready) begin
          w_kill      = 1'b1;
          w_state_nxt = S_RUN;
          w_pc_nxt    = w_b_hit ? w_b_pc  : r_ppc;
          w_fwd       = w_b_hit ? w_b_cls : w_pcls;
        end else if (w_b_hit) begin
          w_pidx_nxt = w_b_idx;
          w_ppc_nxt  = w_b_pc;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_ppc   <= '0;
      r_pidx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ppc   <= w_ppc_nxt;
      r_pidx  <= w_pidx_nxt;
    end
  end

`ifdef NPC_ALIGN_CHECK_EN
  logic r_adel;
  // Sequential steps are always word aligned, so any misalignment came from a redirect or predictor.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_adel <= 1'b0;
    end else if (w_pc_nxt != r_pc) begin
      r_adel <= |w_pc_nxt[1:0];
    end
  end
  assign fetch_adel = r_adel;
`endif

  assign fetch_valid  = (r_state != S_BOOT);
  assign fetch_pc     = r_pc;
  assign fetch_kill   = w_kill;
  assign forward_type = w_fwd;

endmodule

// File: tb/tb_npc_gen.sv
// Scoreboard bench for npc_gen: directed scenarios then randomized traffic against a reference model.
module tb_npc_gen;
  import npc_gen_pkg::*;

  localparam int NR  = 4;
  localparam int NWB = 2;
  localparam int FW  = 2;
  localparam int STEP = 4 * FW;
  localparam logic [31:0] RPC = 32'hBFC00000;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b1;
  logic [NR-1:0]        redir_valid = '0;
  logic [NR*32-1:0]     redir_pc = '0;
  logic                 replay = 1'b0;
  logic                 pred_taken = 1'b0;
  logic [31:0]          pred_pc = '0;
  logic                 fetch_valid;
  logic [31:0]          fetch_pc;
  logic                 fetch_ready = 1'b0;
  logic                 fetch_kill;
  forward_pc_type_t     forward_type;
`ifdef NPC_ALIGN_CHECK_EN
  logic                 fetch_adel;
`endif

  npc_gen #(.NUM_REDIR(NR), .NUM_WB_REDIR(NWB), .FETCH_WIDTH(FW), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .replay       (replay),
    .pred_taken   (pred_taken),
    .pred_pc      (pred_pc),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .fetch_ready  (fetch_ready),
    .fetch_kill   (fetch_kill),
    .forward_type (forward_type)
`ifdef NPC_ALIGN_CHECK_EN
    ,
    .fetch_adel   (fetch_adel)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        k;
    forward_pc_type_t ft;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] tgt [NR];
  bit          m_run, m_pend;
  logic [31:0] m_pc, m_ppc;
  int          m_pidx;

  function automatic forward_pc_type_t cls(input int i);
    return (i < NWB) ? PCW : PCM;
  endfunction

  function automatic int lowest(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, push the expected outputs for it, advance the model.
  task automatic step(input logic rn, input logic rdy, input logic [NR-1:0] rv,
                      input logic rep, input logic pt, input logic [31:0] ppc);
    exp_t e;
    int   i;
    bit   win;
    @(negedge clk);
    resetn = rn; fetch_ready = rdy; redir_valid = rv;
    replay = rep; pred_taken = pt; pred_pc = ppc;
    for (int j = 0; j < NR; j++) redir_pc[j*32 +: 32] = tgt[j];
    #1;
    i = lowest(rv);
    if (!rn) begin
      m_run = 0; m_pend = 0; m_pc = RPC;
      e = '{v: 1'b0, pc: RPC, k: 1'b0, ft: NO_FORWARD};
    end else begin
      e = '{v: (m_run || m_pend), pc: m_pc, k: (m_pend && rdy), ft: NO_FORWARD};
      if (!m_run && !m_pend) begin
        m_run = 1;
      end else if (m_run) begin
        if (i >= 0 && rdy) begin
          e.ft = cls(i);
          m_pc = tgt[i];
        end else if (i >= 0) begin
          m_run = 0; m_pend = 1; m_pidx = i; m_ppc = tgt[i];
        end else if (rdy) begin
          if (rep)      m_pc = m_pc;
          else if (pt)  m_pc = ppc;
          else          m_pc = m_pc - (m_pc % STEP) + STEP;
        end
      end else begin
        win = (i >= 0) && (i <= m_pidx);
        if (rdy) begin
          e.ft = win ? cls(i) : cls(m_pidx);
          m_pc = win ? tgt[i] : m_ppc;
          m_pend = 0; m_run = 1;
        end else if (win) begin
          m_pidx = i; m_ppc = tgt[i];
        end
      end
    end
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fetch_valid",  32'(fetch_valid),  32'(e.v));
        chk("fetch_pc",     fetch_pc,          e.pc);
        chk("fetch_kill",   32'(fetch_kill),   32'(e.k));
        chk("forward_type", 32'(forward_type), 32'(e.ft));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    for (int j = 0; j < NR; j++) tgt[j] = '0;
    m_run = 0; m_pend = 0; m_pc = RPC; m_ppc = '0; m_pidx = 0;
    #1 resetn = 1'b0;
    step(0, 1, '0, 0, 0, 0);
    step(0, 1, '0, 0, 0, 0);
    // Boot and sequential stepping
    repeat (4) step(1, 1, '0, 0, 0, 0);
    // Misaligned start, then block-aligned step
    tgt[0] = 32'hBFC00004;
    step(1, 1, 4'b0001, 0, 0, 0);
    step(1, 1, '0, 0, 0, 0);
    // Predictor and replay
    step(1, 1, '0, 0, 1, 32'h80001000);
    step(1, 1, '0, 1, 1, 32'h12345678);
    step(1, 1, '0, 0, 0, 0);
    // Two sources live: index 1 wins, PCW
    tgt[1] = 32'hBFC00380; tgt[3] = 32'h00400100;
    step(1, 1, 4'b1010, 0, 1, 32'h11110000);
    step(1, 1, '0, 0, 0, 0);
    // Address wrap
    tgt[2] = 32'hFFFFFFF8;
    step(1, 1, 4'b0100, 0, 0, 0);
    step(1, 1, '0, 0, 0, 0);
    step(1, 1, '0, 0, 0, 0);
    // Stalled redirects: idx3 captured, idx0 overwrites, kill on release
    step(1, 0, '0, 0, 0, 0);
    step(1, 0, 4'b1000, 0, 0, 0);
    step(1, 0, '0, 0, 1, 32'h22220000);
    tgt[0] = 32'h80000180;
    step(1, 0, 4'b0001, 0, 0, 0);
    step(1, 0, 4'b1000, 1, 0, 0);
    step(1, 1, '0, 0, 0, 0);
    step(1, 1, '0, 0, 0, 0);
    // Reset while pending discards the entry
    step(1, 0, 4'b0100, 0, 0, 0);
    step(0, 0, '0, 0, 0, 0);
    step(0, 1, '0, 0, 0, 0);
    step(1, 1, '0, 0, 0, 0);
    step(1, 1, '0, 0, 0, 0);
    step(1, 1, '0, 0, 0, 0);
    // Randomized traffic
    repeat (3000) begin
      for (int j = 0; j < NR; j++)
        tgt[j] = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFFFFFC);
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) == 0) ? NR'($urandom) : '0,
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 2) == 0),
           $urandom & 32'hFFFFFFFC);
    end
    step(1, 1, '0, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
